kws_uart_rx_stream: RTL and testbench

- UART receive front end for the KWS MLP OCM design on Arty A7-100T.
- Consumes the raw `usb_uart_rxd` pin and deserialises 8N1 frames.
- Buffers received bytes in a small FIFO and presents them as an AXI4-Stream byte master to the inference input loader.
- Sits directly upstream of the block-design UART consumer; replaces free-running UART IP so host-side feature frames can be back-pressured and counted.

---
 rtl/kws_uart_rx_stream_if.sv | 16 +
 rtl/kws_uart_rx_stream.sv | 230 +++++++++++++++++++++++
 tb/tb_kws_uart_rx_stream.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/kws_uart_rx_stream_if.sv
// ============================================================================
// kws_uart_rx_stream_if : AXI4-Stream byte channel (tdata/tvalid/tready)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface kws_uart_rx_stream_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/kws_uart_rx_stream.sv
// ============================================================================
// kws_uart_rx_stream : UART 8N1 receiver + FWFT byte FIFO -> AXI4-Stream.
// Optional macro UART_RX_PARITY_EN selects 8E1 frames with parity checking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module kws_uart_rx_stream #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 16
) (
  input  wire logic                          sys_clock,
  input  wire logic                          reset,
  input  wire logic                          usb_uart_rxd,
  kws_uart_rx_stream_if.master               m_axis,
  output logic                               frame_err,
  output logic                               overrun,
  output logic                               parity_err,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

  localparam int C_DIV   = (CLK_FREQ_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int C_DIV_W = $clog2(C_DIV);
  localparam int C_OS_W  = $clog2(OVERSAMPLE);
  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam int C_LVL_W = C_PTR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_WAIT_HI = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [C_DIV_W-1:0]   r_div_cnt;
  logic [C_OS_W-1:0]    r_tick_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_push;
  logic                 r_frame_err;
  logic                 w_tick;
  logic                 w_half;
  logic                 w_full;
  logic                 w_cnt_wrap;
  logic                 w_start_entry;
  logic                 w_push;
  logic                 w_frame_err;
  logic                 w_par_bad;

  assign w_tick     = (r_div_cnt == C_DIV_W'(C_DIV - 1));
  assign w_half     = w_tick && (r_tick_cnt == C_OS_W'(OVERSAMPLE / 2 - 1));
  assign w_full     = w_tick && (r_tick_cnt == C_OS_W'(OVERSAMPLE - 1));
  // START only waits half a bit; every other state counts whole bits.
  assign w_cnt_wrap = (r_state == ST_START) ? w_half : w_full;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  logic w_parity_err;

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_parity_err;
      if (w_start_entry)
        r_par_bad <= 1'b0;
      else if (w_parity_err)
        r_par_bad <= 1'b1;
    end
  end

  assign w_par_bad  = r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_start_entry = 1'b0;
    w_push        = 1'b0;
    w_frame_err   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parity_err  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt   = ST_START;
          w_start_entry = 1'b1;
        end
      end
      ST_START: begin
        if (w_half)
          w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_full && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_full) begin
          w_parity_err = (^r_shift) ^ r_rx_s;
          w_state_nxt  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_full) begin
          if (r_rx_s) begin
            w_push      = !w_par_bad;
            w_state_nxt = ST_IDLE;
          end else begin
            // a parity failure already reported this frame
            w_frame_err = !w_par_bad;
            w_state_nxt = ST_WAIT_HI;
          end
        end
      end
      ST_WAIT_HI: begin
        if (r_rx_s)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= ST_IDLE;
      r_div_cnt   <= '0;
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= usb_uart_rxd;
      r_rx_s      <= r_rx_meta;
      r_state     <= w_state_nxt;
      r_push      <= w_push;
      r_frame_err <= w_frame_err;
      if (w_start_entry) begin
        r_div_cnt  <= '0;
        r_tick_cnt <= '0;
        r_bit_idx  <= '0;
      end else begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + C_DIV_W'(1);
        if (w_tick)
          r_tick_cnt <= w_cnt_wrap ? '0 : r_tick_cnt + C_OS_W'(1);
      end
      if ((r_state == ST_DATA) && w_full) begin
        r_shift[r_bit_idx] <= r_rx_s;
        r_bit_idx          <= r_bit_idx + 3'd1;
      end
    end
  end

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_LVL_W-1:0] r_level;
  logic [7:0]         r_tdata;
  logic               r_tvalid;
  logic               r_overrun;
  logic               w_pop;
  logic               w_is_full;
  logic               w_wr;
  logic [C_LVL_W-1:0] w_remain;

  assign w_pop     = r_tvalid && m_axis.tready;
  assign w_is_full = (r_level == C_LVL_W'(FIFO_DEPTH));
  assign w_wr      = r_push && (!w_is_full || w_pop);
  // entries present before this edge's push; a fresh push becomes visible a cycle later
  assign w_remain  = r_level - C_LVL_W'(w_pop);

  always_ff @(posedge sys_clock) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_push && w_is_full && !w_pop;
      r_level   <= r_level + C_LVL_W'(w_wr) - C_LVL_W'(w_pop);
      r_tvalid  <= (w_remain != '0);
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      if (w_remain != '0)
        r_tdata <= r_mem[r_rd_ptr + C_PTR_W'(w_pop)];
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign frame_err     = r_frame_err;
  assign overrun       = r_overrun;
  assign fifo_level    = r_level;

endmodule

`default_nettype wire

// File: tb/tb_kws_uart_rx_stream.sv
// ============================================================================
// tb_kws_uart_rx_stream : directed UART frames against a byte-queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_kws_uart_rx_stream;

  localparam int CLK_HZ = 6_400_000;
  localparam int BAUD   = 100_000;
  localparam int OS     = 16;
  localparam int DEPTH  = 16;
  localparam int BIT    = 64;   // clocks per bit: (6.4e6 / (100e3*16)) * 16

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic [4:0] fifo_level;

  kws_uart_rx_stream_if axis ();

  kws_uart_rx_stream #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD),
    .OVERSAMPLE  (OS),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .sys_clock    (clk),
    .reset        (rst_n),
    .usb_uart_rxd (rxd),
    .m_axis       (axis),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .parity_err   (parity_err),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  int         n_beats = 0;
  logic [7:0] last_beat = 8'h00;
  int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int         exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic       prev_wait = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Compare process: every beat against the model queue, plus hold/valid rules.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_wait) begin
        check("hold_valid", int'(axis.tvalid), 1);
        check("hold_data", int'(axis.tdata), int'(prev_data));
      end
      if (axis.tvalid)
        check("valid_level_nonzero", int'(fifo_level != 5'd0), 1);
      check("level_bound", int'(fifo_level <= 5'd16), 1);
      if (axis.tvalid && axis.tready) begin
        n_beats++;
        last_beat = axis.tdata;
        if (exp_q.size() == 0)
          check("unexpected_beat", int'(axis.tdata), -1);
        else
          check("beat_data", int'(axis.tdata), int'(exp_q.pop_front()));
      end
      fe_cnt += int'(frame_err);
      ov_cnt += int'(overrun);
      pe_cnt += int'(parity_err);
      prev_wait = axis.tvalid && !axis.tready;
      prev_data = axis.tdata;
    end else begin
      prev_wait = 1'b0;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_wrong);
    rxd = 1'b0;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      clks(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ par_wrong;
    clks(BIT);
`else
    if (par_wrong) rxd = 1'b1;
`endif
    rxd = stop_bit;
    clks(BIT);
  endtask

  task automatic good_byte(input logic [7:0] b);
    exp_q.push_back(b);
    send_byte(b, 1'b1, 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    clks(8);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_frame_err"}, fe_cnt, exp_fe);
    check({tag, "_overrun"}, ov_cnt, exp_ov);
    check({tag, "_parity_err"}, pe_cnt, exp_pe);
  endtask

  initial begin
    rst_n       = 1'b0;
    rxd         = 1'b1;
    axis.tready = 1'b1;
    clks(5);
    check("rst_tvalid", int'(axis.tvalid), 0);
    check("rst_tdata", int'(axis.tdata), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_errs", int'({frame_err, overrun, parity_err}), 0);
    rst_n = 1'b1;
    clks(2 * BIT);

    // single byte
    good_byte(8'h55);
    wait_drain();
    check("t1_beats", n_beats, 1);
    check("t1_literal", int'(last_beat), 8'h55);
    check("t1_level", int'(fifo_level), 0);
    check_errs("t1");

    // back to back, no idle between frames
    good_byte(8'hA3);
    good_byte(8'h0F);
    wait_drain();
    check("t2_beats", n_beats, 3);
    check("t2_literal", int'(last_beat), 8'h0F);
    check_errs("t2");

    // 0.35-bit glitch must be ignored
    rxd = 1'b0;
    clks(22);
    rxd = 1'b1;
    clks(3 * BIT);
    check("t3_beats", n_beats, 3);
    check_errs("t3");

    // stop bit low then a long break: one frame_err only
    send_byte(8'h81, 1'b0, 1'b0);
    exp_fe++;
    clks(30 * BIT);
    rxd = 1'b1;
    clks(2 * BIT);
    good_byte(8'h42);
    wait_drain();
    check("t4_beats", n_beats, 4);
    check("t4_literal", int'(last_beat), 8'h42);
    check_errs("t4");

    // fill past full with tready low
    axis.tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 1'b0);
    end
    exp_ov++;
    clks(8);
    check("t5_level_full", int'(fifo_level), 16);
    check("t5_tvalid", int'(axis.tvalid), 1);
    check("t5_head", int'(axis.tdata), 8'h00);
    check_errs("t5");
    axis.tready = 1'b1;
    wait_drain();
    check("t5_beats", n_beats, 20);
    check("t5_level_empty", int'(fifo_level), 0);
    check("t5_tvalid_low", int'(axis.tvalid), 0);
    check("t5_tdata_hold", int'(axis.tdata), 8'h0F);

    // reset mid-frame at data bit 4 of 0xFF
    rxd = 1'b0;
    clks(BIT);
    rxd = 1'b1;
    clks(4 * BIT + BIT / 2);
    rst_n = 1'b0;
    clks(5);
    check("t6_rst_tvalid", int'(axis.tvalid), 0);
    check("t6_rst_tdata", int'(axis.tdata), 0);
    check("t6_rst_level", int'(fifo_level), 0);
    rst_n = 1'b1;
    clks(6 * BIT);
    good_byte(8'h3C);
    wait_drain();
    check("t6_beats", n_beats, 21);
    check("t6_literal", int'(last_beat), 8'h3C);
    check_errs("t6");

`ifdef UART_RX_PARITY_EN
    send_byte(8'h3C, 1'b1, 1'b1);
    exp_pe++;
    clks(4 * BIT);
    check("t7_beats", n_beats, 21);
    check("t7_level", int'(fifo_level), 0);
    check_errs("t7");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
